// File: rtl/maf_pkg.sv
// Shared types and constants for the multiply-add result collector.
// Field bounds follow the IEEE-754 single-precision layout.
package maf_pkg;

    localparam int DW       = 32;
    localparam int EXP_HI   = 30;
    localparam int EXP_LO   = 23;
    localparam int MAN_HI   = 22;
    localparam int MAN_LO   = 0;
    localparam logic [EXP_HI-EXP_LO:0] EXP_ONES = '1;

    localparam int FLG_NAN  = 3;
    localparam int FLG_INF  = 2;
    localparam int FLG_ZERO = 1;
    localparam int FLG_DEN  = 0;

    typedef struct packed {
        logic [3:0]    flags;
        logic [DW-1:0] data;
    } res_entry_t;

    // Sign bit is deliberately ignored; at most one flag is ever set.
    function automatic logic [3:0] classify(input logic [DW-1:0] v);
        logic [EXP_HI-EXP_LO:0] e;
        logic                   man_nz;
        logic [3:0]             f;
        e      = v[EXP_HI:EXP_LO];
        man_nz = |v[MAN_HI:MAN_LO];
        f      = '0;
        f[FLG_NAN]  = (e == EXP_ONES) &&  man_nz;
        f[FLG_INF]  = (e == EXP_ONES) && !man_nz;
        f[FLG_ZERO] = (e == '0)       && !man_nz;
        f[FLG_DEN]  = (e == '0)       &&  man_nz;
        return f;
    endfunction

endpackage

// File: rtl/maf_res_collector_if.sv
// Result strobe in, classified results out over valid/ready.
interface maf_res_collector_if #(parameter int DW = 32);

    logic          res_rdy;
    logic [DW-1:0] res;
    logic          out_vld;
    logic [DW-1:0] out_data;
    logic [3:0]    out_flags;
    logic          out_rdy;

    modport slave (
        input  res_rdy, res, out_rdy,
        output out_vld, out_data, out_flags
    );

    modport master (
        output res_rdy, res, out_rdy,
        input  out_vld, out_data, out_flags
    );

endinterface

// File: rtl/maf_res_fifo.sv
// Synchronous FIFO of classified results; explicit level separates full from empty.
// Head is read combinationally from storage and forced to zero while empty.
module maf_res_fifo
    import maf_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  res_entry_t    wdata,
    output res_entry_t    rdata,
    output logic [LW-1:0] level,
    output logic [LW-1:0] level_nxt,
    output logic          full,
    output logic          empty
);

    res_entry_t      mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic            do_push, do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty && !clr;
    // A full FIFO still takes a write when the head leaves on the same edge.
    assign do_push = push && !clr && (!full || do_pop);

    always_comb begin
        level_nxt = level;
        if (clr)
            level_nxt = '0;
        else if (do_push && !do_pop)
            level_nxt = level + 1'b1;
        else if (do_pop && !do_push)
            level_nxt = level - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (clr) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (do_push) wptr <= wptr + 1'b1;
                if (do_pop)  rptr <= rptr + 1'b1;
            end
            level <= level_nxt;
        end
    end

    assign rdata = empty ? '0 : mem[rptr];

endmodule

// File: rtl/maf_res_collector.sv
// Captures multiply-add results, classifies them, buffers and drains them to a consumer.
// The producer cannot stall, so almost_full throttles the issuer and ovf records drops.
module maf_res_collector
    import maf_pkg::*;
#(
    parameter  int DW        = maf_pkg::DW,
    parameter  int DEPTH     = 8,
    parameter  int AF_MARGIN = 3,
    parameter  int CNT_W     = 16,
    localparam int LW        = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    maf_res_collector_if.slave   bus,
    output logic                 almost_full,
    output logic                 ovf,
    output logic [CNT_W-1:0]     res_cnt,
    output logic [LW-1:0]        level
);

    logic [DW-1:0] res_d;
    res_entry_t    wentry, head;
    logic          push, pop, full, empty;
    logic [LW-1:0] level_nxt;

    assign res_d        = bus.res;
    assign wentry.flags = classify(res_d);
    assign wentry.data  = res_d;

    assign pop  = !empty && bus.out_rdy && !clr;
    assign push = bus.res_rdy && !clr && (!full || pop);

    maf_res_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .push      (push),
        .pop       (pop),
        .wdata     (wentry),
        .rdata     (head),
        .level     (level),
        .level_nxt (level_nxt),
        .full      (full),
        .empty     (empty)
    );

    assign bus.out_vld   = !empty;
    assign bus.out_data  = head.data;
    assign bus.out_flags = head.flags;

    // Registered from the next level so it tracks level cycle-exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full <= 1'b0;
            ovf         <= 1'b0;
            res_cnt     <= '0;
        end else begin
            almost_full <= (level_nxt >= LW'(DEPTH - AF_MARGIN));
            if (clr) begin
                ovf     <= 1'b0;
                res_cnt <= '0;
            end else begin
                if (bus.res_rdy && full && !pop)
                    ovf <= 1'b1;
                if (push)
                    res_cnt <= res_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_maf_res_collector.sv
// Directed + random bench for maf_res_collector against a queue-based reference model.
module tb_maf_res_collector;
    import maf_pkg::*;

    localparam int DEPTH = 8;
    localparam int AFM   = 3;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr = 1'b0;
    logic             almost_full, ovf;
    logic [CNT_W-1:0] res_cnt;
    logic [3:0]       level;

    always #5 clk = ~clk;

    maf_res_collector_if #(.DW(32)) bus ();

    maf_res_collector #(.DW(32), .DEPTH(DEPTH), .AF_MARGIN(AFM), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .bus         (bus),
        .almost_full (almost_full),
        .ovf         (ovf),
        .res_cnt     (res_cnt),
        .level       (level)
    );

    int          checks = 0;
    int          errors = 0;
    logic [35:0] q[$];
    bit          m_ovf;
    int          m_cnt;

    function automatic logic [3:0] ref_flags(input logic [31:0] d);
        int unsigned e, m;
        e = (d >> 23) & 32'hFF;
        m = d % (1 << 23);
        if (e == 255) return (m != 0) ? 4'b1000 : 4'b0100;
        if (e == 0)   return (m == 0) ? 4'b0010 : 4'b0001;
        return 4'b0000;
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0: r[30:23] = 8'hFF;
            1: begin r[30:23] = 8'hFF; r[22:0] = '0; end
            2: r[30:0] = '0;
            3: r[30:23] = 8'h00;
            default: ;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".vld"},   36'(bus.out_vld),   36'(n > 0));
        chk({tag, ".data"},  36'(bus.out_data),  (n > 0) ? 36'(q[0][31:0]) : 36'd0);
        chk({tag, ".flags"}, 36'(bus.out_flags), (n > 0) ? 36'(q[0][35:32]) : 36'd0);
        chk({tag, ".level"}, 36'(level),         36'(n));
        chk({tag, ".af"},    36'(almost_full),   36'(n >= DEPTH - AFM));
        chk({tag, ".ovf"},   36'(ovf),           36'(m_ovf));
        chk({tag, ".cnt"},   36'(res_cnt),       36'(m_cnt % (1 << CNT_W)));
    endtask

    // Drive one cycle from a negedge, advance the model on the posedge, check at the next negedge.
    task automatic step(input string tag, input bit p, input logic [31:0] d, input bit r, input bit c);
        bit pop_m, push_m, full_m;
        bus.res_rdy = p;
        bus.res     = d;
        bus.out_rdy = r;
        clr         = c;
        full_m = (q.size() == DEPTH);
        pop_m  = (q.size() > 0) && r && !c;
        push_m = p && !c && (!full_m || pop_m);
        @(posedge clk);
        if (c) begin
            q.delete();
            m_ovf = 0;
            m_cnt = 0;
        end else begin
            if (pop_m) void'(q.pop_front());
            if (push_m) begin
                q.push_back({ref_flags(d), d});
                m_cnt++;
            end
            if (p && full_m && !pop_m) m_ovf = 1;
        end
        @(negedge clk);
        bus.res_rdy = 1'b0;
        bus.out_rdy = 1'b0;
        clr         = 1'b0;
        check_all(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] cls_v [4];
        logic [3:0]  cls_f [4];
        logic [31:0] first;
        cls_v = '{32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h00000001};
        cls_f = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        bus.res_rdy = 1'b0;
        bus.res     = '0;
        bus.out_rdy = 1'b0;
        m_ovf = 0;
        m_cnt = 0;

        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        step("single", 1'b1, 32'h3F800000, 1'b0, 1'b0);
        chk("single.data_const", 36'(bus.out_data), 36'h3F800000);
        chk("single.cnt_const",  36'(res_cnt),      36'd1);
        step("single_pop", 1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            step("class_push", 1'b1, cls_v[i], 1'b0, 1'b0);
            chk("class.flags_const", 36'(bus.out_flags), 36'(cls_f[i]));
            step("class_pop", 1'b0, '0, 1'b1, 1'b0);
        end

        step("clr0", 1'b0, '0, 1'b0, 1'b1);
        first = gen();
        step("fill", 1'b1, first, 1'b0, 1'b0);
        for (int i = 1; i < DEPTH; i++) begin
            step("fill", 1'b1, gen(), 1'b0, 1'b0);
            if (i == DEPTH - AFM - 1) chk("fill.af_at5", 36'(almost_full), 36'd1);
            if (i == DEPTH - AFM - 2) chk("fill.af_at4", 36'(almost_full), 36'd0);
        end
        chk("fill.level8", 36'(level), 36'd8);
        step("overflow", 1'b1, gen(), 1'b0, 1'b0);
        chk("overflow.ovf",  36'(ovf),          36'd1);
        chk("overflow.cnt",  36'(res_cnt),      36'd8);
        chk("overflow.head", 36'(bus.out_data), 36'(first));

        step("clr1", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step("refill", 1'b1, gen(), 1'b0, 1'b0);
        step("full_pushpop", 1'b1, gen(), 1'b1, 1'b0);
        chk("full_pushpop.level", 36'(level), 36'd8);
        chk("full_pushpop.ovf",   36'(ovf),   36'd0);
        for (int i = 0; i < 16; i++)
            step("mixed", 1'($urandom_range(0, 1)), gen(), 1'($urandom_range(0, 1)), 1'b0);

        step("clr2", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step("pre_clr", 1'b1, gen(), 1'b0, 1'b0);
        step("clr_push", 1'b1, gen(), 1'b0, 1'b1);
        chk("clr_push.level", 36'(level),       36'd0);
        chk("clr_push.vld",   36'(bus.out_vld), 36'd0);

        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, gen(), 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        q.delete();
        m_ovf = 0;
        m_cnt = 0;
        check_all("async_rst");
        rst = 1'b0;
        @(negedge clk);
        check_all("post_rst");
        for (int i = 0; i < 20; i++)
            step("post_rst_rand", 1'($urandom_range(0, 1)), gen(), 1'($urandom_range(0, 1)), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
